conv_enc_seq: RTL and testbench

Frame sequencer in front of the IEEE 802.11a convolutional encoder (K=7, rate 1/2).
- Pulls scrambled DATA-field bits from upstream with a valid/ready handshake.
- Appends the 6 zero tail bits, then zero pad bits up to a whole OFDM symbol (multiple of N_DBPS).
- Drives the encoder's bit/valid input and emits a per-input-bit puncture keep mask for the selected code rate (1/2, 2/3, 3/4).

---
 rtl/ofdm_tx_pkg.sv | 52 +++++
 rtl/conv_enc_seq_punct_mask_gen.sv | 40 ++++
 rtl/conv_enc_seq.sv | 172 +++++++++++++++++
 tb/tb_conv_enc_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_tx_pkg.sv
// Shared definitions for the 802.11a transmit path: code-rate encoding,
// tail length, puncture keep masks and the frame sequencer state encoding.
package ofdm_tx_pkg;

  typedef enum logic [1:0] {
    RATE_1_2  = 2'd0,
    RATE_2_3  = 2'd1,
    RATE_3_4  = 2'd2,
    RATE_RSVD = 2'd3
  } rate_e;

  // Zero bits that flush the K=7 encoder back to the all-zero state.
  localparam int TAIL_BITS = 6;

  // Keep masks: bit 0 keeps coded output A, bit 1 keeps coded output B.
  localparam logic [1:0] KEEP_AB = 2'b11;
  localparam logic [1:0] KEEP_A  = 2'b01;
  localparam logic [1:0] KEEP_B  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_TAIL = 3'd2,
    ST_PAD  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Highest puncture phase for a rate; the reserved code behaves as 1/2.
  function automatic logic [1:0] last_phase(input rate_e rate);
    unique case (rate)
      RATE_2_3: return 2'd1;
      RATE_3_4: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

  // Keep mask for a given rate and puncture phase.
  function automatic logic [1:0] keep_lookup(input rate_e rate, input logic [1:0] phase);
    unique case (rate)
      RATE_2_3: return (phase == 2'd0) ? KEEP_AB : KEEP_A;
      RATE_3_4: begin
        unique case (phase)
          2'd0:    return KEEP_AB;
          2'd1:    return KEEP_A;
          default: return KEEP_B;
        endcase
      end
      default:  return KEEP_AB;
    endcase
  endfunction

endpackage

// File: rtl/conv_enc_seq_punct_mask_gen.sv
// Puncture phase counter with keep-mask lookup. The phase steps once per
// issued encoder bit and wraps at the period of the selected code rate.
module punct_mask_gen
  import ofdm_tx_pkg::*;
(
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  rate_e      rate,
  input  logic       clear,
  input  logic       advance,
  output logic [1:0] keep
);

  logic [1:0] phase_q;
  logic [1:0] phase_d;

  // Next phase: clear at frame start, otherwise step and wrap on each issued bit.
  always_comb begin
    // NOTE: default first so every path assigns phase_d and no latch is inferred.
    phase_d = phase_q;
    if (clear) begin
      phase_d = 2'd0;
    end else if (advance) begin
      phase_d = (phase_q >= last_phase(rate)) ? 2'd0 : phase_q + 2'd1;
    end
  end

  // Phase register with synchronous reset.
  always_ff @(posedge sys_clk) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
    if (sys_rst) begin
      phase_q <= 2'd0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign keep = keep_lookup(rate, phase_q);

endmodule

// File: rtl/conv_enc_seq.sv
// Frame sequencer ahead of the K=7 rate-1/2 convolutional encoder. Pulls DATA
// bits from upstream, appends 6 zero tail bits, pads with zeros to a whole
// OFDM symbol and tags every issued bit with its puncture keep mask.
// The final idle cycle after the last issued bit (extra TAIL cycle or PAD with
// sym_cnt back at 0) lets the registered last bit leave before DONE, so DONE
// never carries enc_valid.
module conv_enc_seq
  import ofdm_tx_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int NDBPS_W = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               cfg_start,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [NDBPS_W-1:0] cfg_ndbps,
  input  logic [1:0]         cfg_rate,
  input  logic               up_bit,
  input  logic               up_valid,
  output logic               up_ready,
  output logic               enc_bit,
  output logic               enc_valid,
  output logic [1:0]         punct_keep,
  output logic               busy,
  output logic               done
);

  localparam logic [2:0] TAIL_END  = 3'(TAIL_BITS);
  localparam logic [2:0] TAIL_LAST = 3'(TAIL_BITS - 1);

  state_e             state_q,     state_d;
  logic [LEN_W-1:0]   rem_q,       rem_d;
  logic [2:0]         tail_q,      tail_d;
  logic [NDBPS_W-1:0] sym_q,       sym_d;
  logic [NDBPS_W-1:0] ndbps_q,     ndbps_d;
  rate_e              rate_q,      rate_d;
  logic               enc_bit_q,   enc_bit_d;
  logic               enc_valid_q, enc_valid_d;
  logic [1:0]         keep_q,      keep_d;

  logic               xfer;
  logic               issue;
  logic               issue_bit;
  logic               frame_clr;
  logic [1:0]         gen_keep;
  logic [NDBPS_W-1:0] ndbps_last;
  logic [NDBPS_W-1:0] sym_next;

  assign up_ready = (state_q == ST_DATA);
  assign xfer     = up_valid & up_ready;

  // An N_DBPS of 0 is treated as 1 so the symbol counter still wraps.
  assign ndbps_last = (ndbps_q == '0) ? '0 : ndbps_q - 1'b1;
  assign sym_next   = (sym_q >= ndbps_last) ? '0 : sym_q + 1'b1;

  // Next-state, counters and the bit issued to the encoder this cycle.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    tail_d    = tail_q;
    sym_d     = sym_q;
    ndbps_d   = ndbps_q;
    rate_d    = rate_q;
    issue     = 1'b0;
    issue_bit = 1'b0;
    frame_clr = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          frame_clr = 1'b1;
          ndbps_d   = cfg_ndbps;
          rate_d    = rate_e'(cfg_rate);
          rem_d     = cfg_len;
          sym_d     = '0;
          tail_d    = 3'd0;
          state_d   = (cfg_len == '0) ? ST_TAIL : ST_DATA;
        end
      end

      ST_DATA: begin
        if (xfer) begin
          issue     = 1'b1;
          issue_bit = up_bit;
          sym_d     = sym_next;
          rem_d     = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) begin
            state_d = ST_TAIL;
          end
        end
      end

      ST_TAIL: begin
        if (tail_q == TAIL_END) begin
          // Tail ended exactly on a symbol boundary: no pad needed.
          state_d = ST_DONE;
        end else begin
          issue  = 1'b1;
          sym_d  = sym_next;
          tail_d = tail_q + 3'd1;
          if (tail_q == TAIL_LAST && sym_next != '0) begin
            state_d = ST_PAD;
          end
        end
      end

      ST_PAD: begin
        if (sym_q == '0) begin
          state_d = ST_DONE;
        end else begin
          issue = 1'b1;
          sym_d = sym_next;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    enc_valid_d = issue;
    enc_bit_d   = issue_bit;
    keep_d      = issue ? gen_keep : 2'b00;
  end

  // Puncture phase tracks issued bits only, so upstream gaps leave it untouched.
  punct_mask_gen u_punct (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .rate    (rate_q),
    .clear   (frame_clr),
    .advance (issue),
    .keep    (gen_keep)
  );

  // State, counters, latched configuration and registered encoder outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      tail_q      <= 3'd0;
      sym_q       <= '0;
      ndbps_q     <= '0;
      rate_q      <= RATE_1_2;
      enc_bit_q   <= 1'b0;
      enc_valid_q <= 1'b0;
      keep_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      tail_q      <= tail_d;
      sym_q       <= sym_d;
      ndbps_q     <= ndbps_d;
      rate_q      <= rate_d;
      enc_bit_q   <= enc_bit_d;
      enc_valid_q <= enc_valid_d;
      keep_q      <= keep_d;
    end
  end

  assign enc_bit    = enc_bit_q;
  assign enc_valid  = enc_valid_q;
  assign punct_keep = keep_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_conv_enc_seq.sv
// Self-checking bench for conv_enc_seq: expected encoder bits and keep masks
// are queued as stimulus is driven and popped as enc_valid appears.
module tb_conv_enc_seq;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        cfg_start;
  logic [15:0] cfg_len;
  logic [7:0]  cfg_ndbps;
  logic [1:0]  cfg_rate;
  logic        up_bit;
  logic        up_valid;
  logic        up_ready;
  logic        enc_bit;
  logic        enc_valid;
  logic [1:0]  punct_keep;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic       b;
    logic [1:0] k;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_bad    = 0;

  always #5 sys_clk = ~sys_clk;

  conv_enc_seq dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .cfg_start  (cfg_start),
    .cfg_len    (cfg_len),
    .cfg_ndbps  (cfg_ndbps),
    .cfg_rate   (cfg_rate),
    .up_bit     (up_bit),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .enc_bit    (enc_bit),
    .enc_valid  (enc_valid),
    .punct_keep (punct_keep),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Keep mask for the idx-th issued bit of a frame.
  function automatic logic [1:0] model_keep(input int rate, input int idx);
    if (rate == 1) return (idx % 2 == 0) ? 2'b11 : 2'b01;
    if (rate == 2) begin
      case (idx % 3)
        0:       return 2'b11;
        1:       return 2'b01;
        default: return 2'b10;
      endcase
    end
    return 2'b11;
  endfunction

  // One frame. gaps: up_valid pattern 1,0,0 repeating. ign_at: cycle to pulse a
  // foreign cfg_start. rst_at: cycle to assert sys_rst and abandon the frame.
  task automatic run_frame(input int len, input int ndbps, input int rate,
                           input bit gaps, input int ign_at, input int rst_at);
    int   xfers;
    int   j;
    int   c;
    int   total;
    int   idx;
    int   exp_done;
    bit   data_done;
    bit   seen_done;
    exp_t e;

    exp_q.delete();
    idx       = 0;
    xfers     = 0;
    j         = 0;
    exp_done  = -1;
    seen_done = 1'b0;
    total     = ((len + 6 + ndbps - 1) / ndbps) * ndbps;

    cfg_len   = 16'(len);
    cfg_ndbps = 8'(ndbps);
    cfg_rate  = 2'(rate);
    cfg_start = 1'b1;
    up_valid  = 1'b0;
    @(negedge sys_clk);
    cfg_start = 1'b0;
    c         = 1;
    check("busy_start", 32'(busy), 32'd1);

    data_done = (len == 0);
    if (data_done) begin
      exp_done = total + 2;
      for (int i = 0; i < total; i++) begin
        exp_q.push_back({1'b0, model_keep(rate, idx)});
        idx++;
      end
    end

    while (!seen_done && c < 3000) begin
      if (enc_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("extra_valid", 32'(enc_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("enc_bit", 32'(enc_bit), 32'(e.b));
          check("keep", 32'(punct_keep), 32'(e.k));
        end
      end else begin
        check("keep_idle", 32'(punct_keep), 32'd0);
      end
      check("ready", 32'(up_ready), 32'(!data_done));

      if (done === 1'b1) begin
        seen_done = 1'b1;
        check("done_cycle", 32'(c), 32'(exp_done));
        check("valid_in_done", 32'(enc_valid), 32'd0);
        check("busy_in_done", 32'(busy), 32'd1);
        check("queue_left", 32'(exp_q.size()), 32'd0);
      end

      if (c == rst_at) begin
        sys_rst  = 1'b1;
        up_valid = 1'b0;
        @(negedge sys_clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(enc_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(up_ready), 32'd0);
        check("rst_keep", 32'(punct_keep), 32'd0);
        sys_rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge sys_clk);
          check("post_rst_quiet", 32'({done, enc_valid, busy}), 32'd0);
        end
        exp_q.delete();
        return;
      end

      cfg_start = (c == ign_at);
      if (c == ign_at) begin
        cfg_len   = 16'd3;
        cfg_ndbps = 8'd48;
        cfg_rate  = 2'd2;
      end

      if (!data_done) begin
        up_valid = gaps ? (j % 3 == 0) : 1'b1;
        up_bit   = 1'($urandom);
        if (up_valid) begin
          exp_q.push_back({up_bit, model_keep(rate, idx)});
          idx++;
          xfers++;
          if (xfers == len) begin
            data_done = 1'b1;
            exp_done  = (j + 1) + total - len + 2;
            for (int i = 0; i < total - len; i++) begin
              exp_q.push_back({1'b0, model_keep(rate, idx)});
              idx++;
            end
          end
        end
        j++;
      end else begin
        // Keep offering bits after the data phase; they must not be taken.
        up_valid = !gaps;
        up_bit   = 1'b1;
      end

      @(negedge sys_clk);
      c++;
    end

    check("timeout", 32'(seen_done), 32'd1);
    up_valid = 1'b0;
    @(negedge sys_clk);
    check("busy_after", 32'(busy), 32'd0);
    check("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    sys_rst   = 1'b1;
    cfg_start = 1'b0;
    cfg_len   = '0;
    cfg_ndbps = 8'd24;
    cfg_rate  = 2'd0;
    up_bit    = 1'b0;
    up_valid  = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("reset_out", 32'({up_ready, enc_bit, enc_valid, punct_keep, busy, done}), 32'd0);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("idle_out", 32'({up_ready, enc_valid, busy, done}), 32'd0);

    run_frame(18, 24, 0, 1'b0, 0, 0);   // exact fill
    run_frame(24, 24, 0, 1'b0, 0, 0);   // full pad symbol
    run_frame(10, 48, 2, 1'b0, 0, 0);   // rate 3/4
    run_frame(10, 48, 1, 1'b0, 0, 0);   // rate 2/3
    run_frame(8, 24, 2, 1'b1, 0, 0);    // upstream gaps
    run_frame(0, 24, 0, 1'b0, 0, 0);    // zero length
    run_frame(12, 24, 1, 1'b0, 4, 0);   // start while busy is ignored
    run_frame(20, 24, 0, 1'b0, 0, 5);   // reset mid-DATA
    run_frame(5, 48, 2, 1'b0, 0, 0);    // clean frame after reset
    run_frame(7, 36, 3, 1'b1, 0, 0);    // reserved rate behaves as 1/2

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
